// File: rtl/adder_pkg.sv
// Shared types and limits for the bit-serial adder datapath.
// Latency: none (types and constants only).
// Backpressure: not applicable.
package adder_pkg;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} sadd_state_t;

  localparam int SADD_WIDTH_MAX = 64;

endpackage

// File: rtl/fulladder.sv
// Single-bit full adder cell, used as the bit-slice of the serial adder.
// Latency: combinational.
// Backpressure: not applicable.
module fulladder (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (ci & (a ^ b));

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial WIDTH-bit adder: one fulladder cell, one bit per clock, carry kept in a flop.
// Latency: WIDTH cycles in RUN from the start handshake to done_valid.
// Backpressure: result held in DONE until done_ready; new operands accepted in that same cycle.
module serial_add_ctrl
  import adder_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_valid,
  output logic             start_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             ci,
  output logic             done_valid,
  input  logic             done_ready,
  output logic [WIDTH-1:0] sum,
  output logic             co,
  output logic             ovf,
  output logic             busy
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  sadd_state_t state, state_nxt;

  logic [WIDTH-1:0] a_sh, b_sh;
  logic [WIDTH-1:0] sum_shift;
  logic [CW-1:0]    cnt;
  logic             carry_q;
  logic             fa_s, fa_co;
  logic             accept, last_bit;
  logic [WIDTH-1:0] sum_q;
  logic             co_q, ovf_q;

  assign accept   = start_valid & start_ready;
  assign last_bit = (cnt == CW'(WIDTH - 1));

  fulladder u_fa (
    .a  (a_sh[0]),
    .b  (b_sh[0]),
    .ci (carry_q),
    .s  (fa_s),
    .co (fa_co)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    start_ready = 1'b0;
    done_valid  = 1'b0;
    busy        = 1'b0;
    case (state)
      S_IDLE: begin
        start_ready = 1'b1;
        if (start_valid) state_nxt = S_RUN;
      end
      S_RUN: begin
        busy = 1'b1;
        if (last_bit) state_nxt = S_DONE;
      end
      S_DONE: begin
        done_valid  = 1'b1;
        start_ready = done_ready;
        if (done_ready) state_nxt = start_valid ? S_RUN : S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Partial sum collects the low WIDTH-1 bits; the current cell output completes it.
  if (WIDTH == 1) begin : g_one
    assign sum_shift = fa_s;
  end else begin : g_multi
    logic [WIDTH-2:0] part_q;
    assign sum_shift = {fa_s, part_q};
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)              part_q <= '0;
      else if (state == S_RUN) part_q <= sum_shift[WIDTH-1:1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sh    <= '0;
      b_sh    <= '0;
      carry_q <= 1'b0;
      cnt     <= '0;
      sum_q   <= '0;
      co_q    <= 1'b0;
      ovf_q   <= 1'b0;
    end else if (accept) begin
      a_sh    <= a;
      b_sh    <= b;
      carry_q <= ci;
      cnt     <= '0;
    end else if (state == S_RUN) begin
      a_sh    <= a_sh >> 1;
      b_sh    <= b_sh >> 1;
      carry_q <= fa_co;
      cnt     <= cnt + 1'b1;
      if (last_bit) begin
        sum_q <= sum_shift;
        co_q  <= fa_co;
        // carry_q is the carry into the MSB cell on the last bit
        ovf_q <= carry_q ^ fa_co;
      end
    end
  end

  assign sum = sum_q;
  assign co  = co_q;
  assign ovf = ovf_q;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Directed self-checking bench for serial_add_ctrl at WIDTH=8 and WIDTH=1.
module tb_serial_add_ctrl;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic       sv8, sr8, ci8, dv8, dr8, co8, ovf8, busy8;
  logic [7:0] a8, b8, sum8;

  logic w1_sv, w1_sr, w1_ci, w1_dv, w1_dr, w1_co, w1_ovf, w1_busy;
  logic [0:0] w1_a, w1_b, w1_sum;

  int checks = 0;
  int passes = 0;

  serial_add_ctrl #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n),
    .start_valid(sv8), .start_ready(sr8),
    .a(a8), .b(b8), .ci(ci8),
    .done_valid(dv8), .done_ready(dr8),
    .sum(sum8), .co(co8), .ovf(ovf8), .busy(busy8)
  );

  serial_add_ctrl #(.WIDTH(1)) dut1 (
    .clk(clk), .rst_n(rst_n),
    .start_valid(w1_sv), .start_ready(w1_sr),
    .a(w1_a), .b(w1_b), .ci(w1_ci),
    .done_valid(w1_dv), .done_ready(w1_dr),
    .sum(w1_sum), .co(w1_co), .ovf(w1_ovf), .busy(w1_busy)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // Issue one operation from IDLE, then count RUN cycles until busy drops.
  task automatic run8(input logic [7:0] av, input logic [7:0] bv, input logic cv, output int n);
    sv8 = 1'b1; a8 = av; b8 = bv; ci8 = cv; dr8 = 1'b0;
    @(negedge clk);
    sv8 = 1'b0; a8 = 8'($urandom); b8 = 8'($urandom); ci8 = 1'($urandom);
    n = 0;
    while (busy8 && n < 40) begin
      n++;
      @(negedge clk);
    end
  endtask

  task automatic result8(input string tag, input int n, input logic [7:0] es,
                         input logic ec, input logic eo);
    chk({tag, "_run_cycles"}, 64'(n), 64'd8);
    chk({tag, "_done_valid"}, 64'(dv8), 64'd1);
    chk({tag, "_sum"}, 64'(sum8), 64'(es));
    chk({tag, "_co"}, 64'(co8), 64'(ec));
    chk({tag, "_ovf"}, 64'(ovf8), 64'(eo));
  endtask

  task automatic release8(input string tag);
    dr8 = 1'b1;
    @(negedge clk);
    dr8 = 1'b0;
    chk({tag, "_idle_dv"}, 64'(dv8), 64'd0);
    chk({tag, "_idle_sr"}, 64'(sr8), 64'd1);
  endtask

  initial begin
    int  n;
    logic seen;
    logic [7:0] held_sum;

    sv8 = 0; a8 = 0; b8 = 0; ci8 = 0; dr8 = 0;
    w1_sv = 0; w1_a = 0; w1_b = 0; w1_ci = 0; w1_dr = 0;

    repeat (2) @(negedge clk);
    chk("rst_sr", 64'(sr8), 64'd1);
    chk("rst_dv", 64'(dv8), 64'd0);
    chk("rst_busy", 64'(busy8), 64'd0);
    chk("rst_sum", 64'(sum8), 64'd0);
    chk("rst_co", 64'(co8), 64'd0);
    chk("rst_ovf", 64'(ovf8), 64'd0);
    chk("w1_rst_sr", 64'(w1_sr), 64'd1);
    chk("w1_rst_dv", 64'(w1_dv), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_sr", 64'(sr8), 64'd1);

    run8(8'h5A, 8'h3C, 1'b0, n);
    result8("add_5a_3c", n, 8'h96, 1'b0, 1'b1);
    release8("add_5a_3c");
    chk("hold_after_idle", 64'(sum8), 64'h96);

    run8(8'hFF, 8'h01, 1'b0, n);
    result8("add_ff_01", n, 8'h00, 1'b1, 1'b0);
    release8("add_ff_01");

    run8(8'hFF, 8'h00, 1'b1, n);
    result8("add_ff_00_ci", n, 8'h00, 1'b1, 1'b0);
    release8("add_ff_00_ci");

    run8(8'h7F, 8'h01, 1'b0, n);
    result8("add_7f_01", n, 8'h80, 1'b0, 1'b1);
    release8("add_7f_01");

    run8(8'h80, 8'h80, 1'b0, n);
    result8("add_80_80", n, 8'h00, 1'b1, 1'b1);
    release8("add_80_80");

    // Back-pressure: hold DONE while inputs wiggle, then chain straight into RUN.
    run8(8'h5A, 8'h3C, 1'b0, n);
    result8("bp_first", n, 8'h96, 1'b0, 1'b1);
    for (int i = 0; i < 5; i++) begin
      a8 = 8'($urandom); b8 = 8'($urandom); ci8 = 1'($urandom);
      @(negedge clk);
      chk("bp_dv", 64'(dv8), 64'd1);
      chk("bp_sr", 64'(sr8), 64'd0);
      chk("bp_sum", 64'(sum8), 64'h96);
      chk("bp_co", 64'(co8), 64'd0);
      chk("bp_ovf", 64'(ovf8), 64'd1);
    end
    sv8 = 1'b1; a8 = 8'h01; b8 = 8'h02; ci8 = 1'b0; dr8 = 1'b1;
    #1;
    chk("b2b_sr", 64'(sr8), 64'd1);
    @(negedge clk);
    sv8 = 1'b0; dr8 = 1'b0; a8 = 8'hAA; b8 = 8'h55;
    chk("b2b_busy", 64'(busy8), 64'd1);
    chk("b2b_dv", 64'(dv8), 64'd0);
    held_sum = sum8;
    chk("b2b_sum_held", 64'(held_sum), 64'h96);
    n = 0;
    while (busy8 && n < 40) begin
      n++;
      @(negedge clk);
    end
    result8("b2b_second", n, 8'h03, 1'b0, 1'b0);
    release8("b2b_second");

    // Reset on the third RUN cycle aborts everything.
    sv8 = 1'b1; a8 = 8'hFF; b8 = 8'h01; ci8 = 1'b0;
    @(negedge clk);
    sv8 = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("abort_sr", 64'(sr8), 64'd1);
    chk("abort_dv", 64'(dv8), 64'd0);
    chk("abort_busy", 64'(busy8), 64'd0);
    chk("abort_sum", 64'(sum8), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("abort_release_sr", 64'(sr8), 64'd1);
    seen = 1'b0;
    repeat (15) begin
      @(negedge clk);
      if (dv8 || busy8) seen = 1'b1;
    end
    chk("abort_no_spurious", 64'(seen), 64'd0);

    run8(8'h12, 8'h34, 1'b1, n);
    result8("post_abort", n, 8'h47, 1'b0, 1'b0);
    release8("post_abort");

    // WIDTH=1 instance: single RUN cycle, ovf = ci ^ co.
    w1_sv = 1'b1; w1_a = 1'b1; w1_b = 1'b1; w1_ci = 1'b1;
    @(negedge clk);
    w1_sv = 1'b0; w1_a = 1'b0; w1_b = 1'b0; w1_ci = 1'b0;
    n = 0;
    while (w1_busy && n < 10) begin
      n++;
      @(negedge clk);
    end
    chk("w1_run_cycles", 64'(n), 64'd1);
    chk("w1_dv", 64'(w1_dv), 64'd1);
    chk("w1_sum", 64'(w1_sum), 64'd1);
    chk("w1_co", 64'(w1_co), 64'd1);
    chk("w1_ovf", 64'(w1_ovf), 64'd0);
    w1_dr = 1'b1;
    @(negedge clk);
    w1_dr = 1'b0;
    chk("w1_idle_dv", 64'(w1_dv), 64'd0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
